sprite_shift_sched: RTL and testbench

//   Per-scanline sprite output scheduler. Holds the up-to-8 sprites fetched for the next line.

---
 rtl/sprite_shift_sched_if.sv | 26 ++
 rtl/sprite_shift_sched.sv | 99 +++++++++
 tb/tb_sprite_shift_sched.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/sprite_shift_sched_if.sv
// sprite_shift_sched_if: dot timing, staging-bank load port and per-slot pixel outputs
interface sprite_shift_sched_if #(parameter int X_W = 8);
   logic              i_pixel_en;
   logic              i_active;
   logic              i_line_start;
   logic              i_load_en;
   logic [2:0]        i_load_slot;
   logic [7:0]        i_load_pat_lo;
   logic [7:0]        i_load_pat_hi;
   logic [7:0]        i_load_attr;
   logic [X_W-1:0]    i_load_x;
   logic              i_load_spr0;
   logic [7:0][3:0]   o_sprite_pixel;
   logic [7:0]        o_sprite_priority_buff;
   logic              o_spr0_opaque;
   modport slave (
      input  i_pixel_en, i_active, i_line_start, i_load_en, i_load_slot,
             i_load_pat_lo, i_load_pat_hi, i_load_attr, i_load_x, i_load_spr0,
      output o_sprite_pixel, o_sprite_priority_buff, o_spr0_opaque
   );
   modport master (
      output i_pixel_en, i_active, i_line_start, i_load_en, i_load_slot,
             i_load_pat_lo, i_load_pat_hi, i_load_attr, i_load_x, i_load_spr0,
      input  o_sprite_pixel, o_sprite_priority_buff, o_spr0_opaque
   );
endinterface

// File: rtl/sprite_shift_sched.sv
// sprite_shift_sched: double-buffered 8-slot sprite X down-counter and pattern shifter
module sprite_shift_sched #(
   parameter int NUM_SLOTS = 8,
   parameter int X_W       = 8
) (
   input logic                  clk,
   input logic                  rst_n,
   sprite_shift_sched_if.slave  bus
);
   logic [7:0]     r_s_lo [NUM_SLOTS];
   logic [7:0]     r_s_hi [NUM_SLOTS];
   logic [1:0]     r_s_pal [NUM_SLOTS];
   logic [X_W-1:0] r_s_x [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] r_s_prio, r_s_spr0, r_s_vld;
   logic [7:0]     r_w_lo [NUM_SLOTS];
   logic [7:0]     r_w_hi [NUM_SLOTS];
   logic [1:0]     r_w_pal [NUM_SLOTS];
   logic [X_W-1:0] r_w_cnt [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] r_w_prio, r_w_spr0, r_w_vld;
   logic w_xfer, w_run, w_hflip, w_unused;
   logic [7:0] w_lo, w_hi;

   function automatic logic [7:0] rev8(input logic [7:0] v);
      for (int i = 0; i < 8; i++) rev8[i] = v[7-i];
   endfunction

   assign w_xfer   = bus.i_line_start & bus.i_pixel_en;
   assign w_run    = bus.i_pixel_en & bus.i_active & ~bus.i_line_start;
   assign w_hflip  = bus.i_load_attr[6];
   assign w_lo     = w_hflip ? rev8(bus.i_load_pat_lo) : bus.i_load_pat_lo;
   assign w_hi     = w_hflip ? rev8(bus.i_load_pat_hi) : bus.i_load_pat_hi;
   assign w_unused = ^{bus.i_load_attr[7], bus.i_load_attr[4:2]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int n = 0; n < NUM_SLOTS; n++) begin
            r_s_lo[n]  <= '0;
            r_s_hi[n]  <= '0;
            r_s_pal[n] <= '0;
            r_s_x[n]   <= '0;
            r_w_lo[n]  <= '0;
            r_w_hi[n]  <= '0;
            r_w_pal[n] <= '0;
            r_w_cnt[n] <= '0;
         end
         r_s_prio <= '0;
         r_s_spr0 <= '0;
         r_s_vld  <= '0;
         r_w_prio <= '0;
         r_w_spr0 <= '0;
         r_w_vld  <= '0;
      end else begin
         for (int n = 0; n < NUM_SLOTS; n++) begin
            if (w_xfer) begin
               r_w_lo[n]  <= r_s_lo[n];
               r_w_hi[n]  <= r_s_hi[n];
               r_w_pal[n] <= r_s_pal[n];
               r_w_cnt[n] <= r_s_x[n];
            end else if (w_run) begin
               if (r_w_cnt[n] != '0) r_w_cnt[n] <= r_w_cnt[n] - 1'b1;
               else begin
                  r_w_lo[n] <= {r_w_lo[n][6:0], 1'b0};
                  r_w_hi[n] <= {r_w_hi[n][6:0], 1'b0};
               end
            end
         end
         if (w_xfer) begin
            r_w_prio <= r_s_prio;
            r_w_spr0 <= r_s_spr0;
            r_w_vld  <= r_s_vld;
            r_s_vld  <= '0;
         end
         // placed after the clear so a same-cycle write keeps its valid bit
         if (bus.i_load_en) begin
            r_s_lo[bus.i_load_slot]   <= w_lo;
            r_s_hi[bus.i_load_slot]   <= w_hi;
            r_s_pal[bus.i_load_slot]  <= bus.i_load_attr[1:0];
            r_s_x[bus.i_load_slot]    <= bus.i_load_x;
            r_s_prio[bus.i_load_slot] <= bus.i_load_attr[5];
            r_s_spr0[bus.i_load_slot] <= bus.i_load_spr0;
            r_s_vld[bus.i_load_slot]  <= 1'b1;
         end
      end
   end

   always_comb begin
      bus.o_sprite_pixel         = '0;
      bus.o_sprite_priority_buff = '1;
      bus.o_spr0_opaque          = 1'b0;
      for (int n = 0; n < NUM_SLOTS; n++) begin
         bus.o_sprite_pixel[n] = (r_w_vld[n] && r_w_cnt[n] == '0) ?
                                 {r_w_pal[n], r_w_hi[n][7], r_w_lo[n][7]} : 4'b0000;
         bus.o_sprite_priority_buff[n] = r_w_vld[n] ? r_w_prio[n] : 1'b1;
         bus.o_spr0_opaque = bus.o_spr0_opaque |
                             (r_w_spr0[n] & r_w_vld[n] & (r_w_cnt[n] == '0) &
                              (r_w_hi[n][7] | r_w_lo[n][7]));
      end
   end
endmodule

// File: tb/tb_sprite_shift_sched.sv
// tb_sprite_shift_sched: directed steps with an expected-value queue popped at each sample
module tb_sprite_shift_sched;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_pass = 0;
   int   n_chk  = 0;
   logic [31:0] q_exp [$];

   sprite_shift_sched_if #(.X_W(8)) bus ();
   sprite_shift_sched #(.NUM_SLOTS(8), .X_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs);
      logic [31:0] exp;
      n_chk++;
      if (q_exp.size() == 0) begin
         $error("FAIL %s obs=%h exp=<empty queue>", tag, obs);
         return;
      end
      exp = q_exp.pop_front();
      assert (obs === exp) n_pass++;
      else $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
   endtask

   task automatic load(input int slot, input logic [7:0] lo, input logic [7:0] hi,
                       input logic [7:0] attr, input logic [7:0] x, input logic spr0);
      bus.i_load_en = 1'b1;
      bus.i_load_slot = slot[2:0];
      bus.i_load_pat_lo = lo;
      bus.i_load_pat_hi = hi;
      bus.i_load_attr = attr;
      bus.i_load_x = x;
      bus.i_load_spr0 = spr0;
      step();
      bus.i_load_en = 1'b0;
   endtask

   task automatic new_line();
      bus.i_pixel_en = 1'b1;
      bus.i_line_start = 1'b1;
      bus.i_active = 1'b0;
      step();
      bus.i_pixel_en = 1'b0;
      bus.i_line_start = 1'b0;
   endtask

   // one active dot: push expected pixel of slot, sample before the shifting edge
   task automatic dot_pix(input int slot, input logic [3:0] exp, input string tag);
      bus.i_pixel_en = 1'b1;
      bus.i_active = 1'b1;
      q_exp.push_back({28'h0, exp});
      @(negedge clk);
      chk(tag, {28'h0, bus.o_sprite_pixel[slot]});
      step();
      bus.i_pixel_en = 1'b0;
      bus.i_active = 1'b0;
   endtask

   initial begin
      bus.i_pixel_en = 1'b0;
      bus.i_active = 1'b0;
      bus.i_line_start = 1'b0;
      bus.i_load_en = 1'b0;
      bus.i_load_slot = '0;
      bus.i_load_pat_lo = '0;
      bus.i_load_pat_hi = '0;
      bus.i_load_attr = '0;
      bus.i_load_x = '0;
      bus.i_load_spr0 = 1'b0;
      #2;
      q_exp.push_back(32'h0);
      chk("reset_pix", bus.o_sprite_pixel);
      q_exp.push_back(32'hFF);
      chk("reset_prio", {24'h0, bus.o_sprite_priority_buff});
      step();
      rst_n = 1'b1;
      step();

      // 1: async reset mid-line
      load(0, 8'hFF, 8'h00, 8'h21, 8'd0, 1'b1);
      load(3, 8'hFF, 8'hFF, 8'h03, 8'd0, 1'b0);
      new_line();
      dot_pix(0, 4'b0101, "pre_rst_pix0");
      bus.i_pixel_en = 1'b1;
      bus.i_active = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      q_exp.push_back(32'h0);
      chk("rst_pix", bus.o_sprite_pixel);
      q_exp.push_back(32'hFF);
      chk("rst_prio", {24'h0, bus.o_sprite_priority_buff});
      q_exp.push_back(32'h0);
      chk("rst_opaque", {31'h0, bus.o_spr0_opaque});
      bus.i_pixel_en = 1'b0;
      bus.i_active = 1'b0;
      step();
      rst_n = 1'b1;
      step();

      // 2: X=3 normal orientation
      load(0, 8'hF0, 8'h00, 8'h02, 8'd3, 1'b0);
      new_line();
      for (int d = 0; d <= 10; d++)
         dot_pix(0, d < 3 ? 4'b0000 : d < 7 ? 4'b1001 : 4'b1000, $sformatf("x3_dot%0d", d));

      // 3: same with hflip
      load(0, 8'hF0, 8'h00, 8'h42, 8'd3, 1'b0);
      new_line();
      for (int d = 0; d <= 10; d++)
         dot_pix(0, d < 3 ? 4'b0000 : d < 7 ? 4'b1000 : 4'b1001, $sformatf("hflip_dot%0d", d));

      // 4: priority buffer and staging clear
      load(5, 8'hFF, 8'h00, 8'h20, 8'd10, 1'b0);
      new_line();
      q_exp.push_back(32'hFF);
      chk("prio_behind", {24'h0, bus.o_sprite_priority_buff});
      load(5, 8'hFF, 8'h00, 8'h00, 8'd0, 1'b0);
      new_line();
      q_exp.push_back(32'hDF);
      chk("prio_front", {24'h0, bus.o_sprite_priority_buff});
      dot_pix(5, 4'b0001, "slot5_shown");
      new_line();
      q_exp.push_back(32'hFF);
      chk("prio_cleared", {24'h0, bus.o_sprite_priority_buff});
      dot_pix(5, 4'b0000, "slot5_cleared");

      // 5: load in the same cycle as line_start
      bus.i_load_en = 1'b1;
      bus.i_load_slot = 3'd2;
      bus.i_load_pat_lo = 8'hFF;
      bus.i_load_pat_hi = 8'h00;
      bus.i_load_attr = 8'h03;
      bus.i_load_x = 8'd1;
      bus.i_load_spr0 = 1'b0;
      new_line();
      bus.i_load_en = 1'b0;
      q_exp.push_back(32'hFF);
      chk("same_cyc_prio", {24'h0, bus.o_sprite_priority_buff});
      dot_pix(2, 4'b0000, "same_cyc_dot0");
      dot_pix(2, 4'b0000, "same_cyc_dot1");
      new_line();
      q_exp.push_back(32'hFB);
      chk("next_line_prio", {24'h0, bus.o_sprite_priority_buff});
      dot_pix(2, 4'b0000, "next_line_dot0");
      dot_pix(2, 4'b1101, "next_line_dot1");

      // 6: sprite 0 at X=255
      load(1, 8'h80, 8'h00, 8'h00, 8'd255, 1'b1);
      new_line();
      for (int d = 0; d <= 255; d++) begin
         bus.i_pixel_en = 1'b1;
         bus.i_active = 1'b1;
         q_exp.push_back({31'h0, d == 255});
         @(negedge clk);
         chk($sformatf("spr0_dot%0d", d), {31'h0, bus.o_spr0_opaque});
         step();
      end
      bus.i_active = 1'b0;
      for (int c = 0; c < 4; c++) begin
         q_exp.push_back(32'h0);
         @(negedge clk);
         chk($sformatf("spr0_after%0d", c), {31'h0, bus.o_spr0_opaque});
         q_exp.push_back(32'h0);
         chk($sformatf("pix1_after%0d", c), {28'h0, bus.o_sprite_pixel[1]});
         step();
      end
      bus.i_pixel_en = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
